// File: rtl/riscv_csr_pkg.sv
//------------------------------------------------------------------------------
// Module : riscv_csr_pkg
// Brief  : Shared constants for the machine counter CSRs: data widths and the
//          CSR addresses of mcycle/minstret, their user aliases and
//          mcountinhibit.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_csr_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

endpackage : riscv_csr_pkg

`default_nettype wire

// File: rtl/machine_counter_64.sv
//------------------------------------------------------------------------------
// Module : machine_counter_64
// Brief  : One 64-bit machine counter with conditional increment and
//          independent writes to its low and high 32-bit halves.
// Ports  : clk      in   clock
//          rst      in   asynchronous reset, active-high
//          inc_en   in   increment by one this edge
//          wr_lo    in   write wr_data into cnt[31:0] (increment suppressed)
//          wr_hi    in   write wr_data into cnt[63:32] (low carry discarded)
//          wr_data  in   32-bit write data
//          cnt      out  counter value (the register itself)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module machine_counter_64
    import riscv_csr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [XLEN-1:0]  wr_data,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [XLEN:0]    lo_sum;   // low half plus increment, with carry out

    always_comb begin
        lo_sum = {1'b0, cnt_q[XLEN-1:0]} + {{XLEN{1'b0}}, inc_en};
        cnt_d  = {cnt_q[CNT_W-1:XLEN] + {{(XLEN-1){1'b0}}, lo_sum[XLEN]},
                  lo_sum[XLEN-1:0]};
        if (wr_lo) begin
            // Low write replaces the increment entirely, so no carry is possible.
            cnt_d = {cnt_q[CNT_W-1:XLEN], wr_data};
        end else if (wr_hi) begin
            // High write wins over the carry; the low half still counts.
            cnt_d = {wr_data, lo_sum[XLEN-1:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : machine_counter_64

`default_nettype wire

// File: rtl/machine_counters.sv
//------------------------------------------------------------------------------
// Module : machine_counters
// Brief  : mcycle and minstret 64-bit counters with CSR write decode, read-only
//          user alias detection and a registered CSR read port.
// Ports  : clk_in               in   clock
//          rst_in               in   asynchronous reset, active-high
//          wr_en_in             in   CSR write strobe
//          rd_en_in             in   CSR read strobe
//          csr_addr_in[11:0]    in   CSR address (shared by read and write)
//          data_wr_in[31:0]     in   CSR write data
//          instret_inc_in       in   one instruction retired this cycle
//          mcountinhibit_cy_in  in   1 = freeze mcycle
//          mcountinhibit_ir_in  in   1 = freeze minstret
//          data_rd_out[31:0]    out  registered read data
//          rd_hit_out           out  registered: last read hit a counter CSR
//          illegal_wr_out       out  registered pulse: write to read-only alias
//          mcycle_out[63:0]     out  current mcycle
//          minstret_out[63:0]   out  current minstret
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module machine_counters
    import riscv_csr_pkg::*;
#(
    parameter logic [11:0] MCYCLE    = CSR_MCYCLE,
    parameter logic [11:0] MINSTRET  = CSR_MINSTRET,
    parameter logic [11:0] MCYCLEH   = CSR_MCYCLEH,
    parameter logic [11:0] MINSTRETH = CSR_MINSTRETH,
    parameter logic [11:0] CYCLE     = CSR_CYCLE,
    parameter logic [11:0] CYCLEH    = CSR_CYCLEH,
    parameter logic [11:0] INSTRET   = CSR_INSTRET,
    parameter logic [11:0] INSTRETH  = CSR_INSTRETH
)(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              wr_en_in,
    input  logic              rd_en_in,
    input  logic [11:0]       csr_addr_in,
    input  logic [XLEN-1:0]   data_wr_in,
    input  logic              instret_inc_in,
    input  logic              mcountinhibit_cy_in,
    input  logic              mcountinhibit_ir_in,
    output logic [XLEN-1:0]   data_rd_out,
    output logic              rd_hit_out,
    output logic              illegal_wr_out,
    output logic [CNT_W-1:0]  mcycle_out,
    output logic [CNT_W-1:0]  minstret_out
);

    // Address decode
    logic sel_mcycle_lo;
    logic sel_mcycle_hi;
    logic sel_minstret_lo;
    logic sel_minstret_hi;
    logic sel_alias;

    assign sel_mcycle_lo   = (csr_addr_in == MCYCLE);
    assign sel_mcycle_hi   = (csr_addr_in == MCYCLEH);
    assign sel_minstret_lo = (csr_addr_in == MINSTRET);
    assign sel_minstret_hi = (csr_addr_in == MINSTRETH);
    assign sel_alias       = (csr_addr_in == CYCLE)   || (csr_addr_in == CYCLEH) ||
                             (csr_addr_in == INSTRET) || (csr_addr_in == INSTRETH);

    // Counters
    logic [CNT_W-1:0] mcycle_cnt;
    logic [CNT_W-1:0] minstret_cnt;

    machine_counter_64 u_mcycle (
        .clk     (clk_in),
        .rst     (rst_in),
        .inc_en  (~mcountinhibit_cy_in),
        .wr_lo   (wr_en_in & sel_mcycle_lo),
        .wr_hi   (wr_en_in & sel_mcycle_hi),
        .wr_data (data_wr_in),
        .cnt     (mcycle_cnt)
    );

    machine_counter_64 u_minstret (
        .clk     (clk_in),
        .rst     (rst_in),
        .inc_en  (instret_inc_in & ~mcountinhibit_ir_in),
        .wr_lo   (wr_en_in & sel_minstret_lo),
        .wr_hi   (wr_en_in & sel_minstret_hi),
        .wr_data (data_wr_in),
        .cnt     (minstret_cnt)
    );

    // Read mux works on the pre-edge counter values, so a read that coincides
    // with a write to the same CSR returns the old contents.
    logic [XLEN-1:0] rd_data_sel;
    logic            rd_hit_sel;

    always_comb begin
        rd_data_sel = '0;
        rd_hit_sel  = 1'b1;
        case (csr_addr_in)
            MCYCLE,   CYCLE:    rd_data_sel = mcycle_cnt[XLEN-1:0];
            MCYCLEH,  CYCLEH:   rd_data_sel = mcycle_cnt[CNT_W-1:XLEN];
            MINSTRET, INSTRET:  rd_data_sel = minstret_cnt[XLEN-1:0];
            MINSTRETH,INSTRETH: rd_data_sel = minstret_cnt[CNT_W-1:XLEN];
            default:            rd_hit_sel  = 1'b0;
        endcase
    end

    // Registered read port and illegal-write pulse
    logic [XLEN-1:0] data_rd_q;
    logic [XLEN-1:0] data_rd_d;
    logic            rd_hit_q;
    logic            rd_hit_d;
    logic            illegal_wr_q;
    logic            illegal_wr_d;

    always_comb begin
        data_rd_d    = data_rd_q;
        rd_hit_d     = rd_hit_q;
        if (rd_en_in) begin
            data_rd_d = rd_data_sel;
            rd_hit_d  = rd_hit_sel;
        end
        illegal_wr_d = wr_en_in & sel_alias;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_rd_q    <= '0;
            rd_hit_q     <= 1'b0;
            illegal_wr_q <= 1'b0;
        end else begin
            data_rd_q    <= data_rd_d;
            rd_hit_q     <= rd_hit_d;
            illegal_wr_q <= illegal_wr_d;
        end
    end

    assign data_rd_out    = data_rd_q;
    assign rd_hit_out     = rd_hit_q;
    assign illegal_wr_out = illegal_wr_q;
    assign mcycle_out     = mcycle_cnt;
    assign minstret_out   = minstret_cnt;

endmodule : machine_counters

`default_nettype wire

// File: tb/tb_machine_counters.sv
//------------------------------------------------------------------------------
// Module : tb_machine_counters
// Brief  : Directed self-checking bench for machine_counters.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_machine_counters;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        inc;
    logic        inh_cy;
    logic        inh_ir;
    logic [31:0] rdata;
    logic        rd_hit;
    logic        illegal;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    int n_checks = 0;
    int n_fail   = 0;

    machine_counters dut (
        .clk_in              (clk),
        .rst_in              (rst),
        .wr_en_in            (wr_en),
        .rd_en_in            (rd_en),
        .csr_addr_in         (addr),
        .data_wr_in          (wdata),
        .instret_inc_in      (inc),
        .mcountinhibit_cy_in (inh_cy),
        .mcountinhibit_ir_in (inh_ir),
        .data_rd_out         (rdata),
        .rd_hit_out          (rd_hit),
        .illegal_wr_out      (illegal),
        .mcycle_out          (mcycle),
        .minstret_out        (minstret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step();
        wr_en = 1'b0; addr = 12'h000; wdata = '0;
    endtask

    task automatic csr_rd(input logic [11:0] a);
        rd_en = 1'b1; addr = a;
        step();
        rd_en = 1'b0; addr = 12'h000;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        inc = 1'b0; inh_cy = 1'b0; inh_ir = 1'b0;
        step(); step();
        check("rst_mcycle",   mcycle,   64'd0);
        check("rst_minstret", minstret, 64'd0);
        check("rst_rdata",    {32'd0, rdata}, 64'd0);
        check("rst_hit",      {63'd0, rd_hit}, 64'd0);
        check("rst_illegal",  {63'd0, illegal}, 64'd0);

        // Free counting after release
        rst = 1'b0;
        step(); step(); step();
        check("free_mcycle",   mcycle,   64'd3);
        check("free_minstret", minstret, 64'd0);

        // Read captures pre-edge value 3
        csr_rd(12'hB00);
        check("rd_mcycle",     {32'd0, rdata}, 64'd3);
        check("rd_mcycle_hit", {63'd0, rd_hit}, 64'd1);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("async_mcycle", mcycle, 64'd0);
        check("async_rdata",  {32'd0, rdata}, 64'd0);
        check("async_hit",    {63'd0, rd_hit}, 64'd0);
        step();
        rst = 1'b0;

        // Inhibit mcycle for 5 cycles
        inh_cy = 1'b1;
        repeat (5) step();
        check("inhibit_cy", mcycle, 64'd0);

        // Three retire pulses
        for (int i = 0; i < 3; i++) begin
            inc = 1'b1; step();
            inc = 1'b0; step();
        end
        check("instret_3", minstret, 64'd3);
        inh_ir = 1'b1; inc = 1'b1;
        step();
        inc = 1'b0;
        check("inhibit_ir", minstret, 64'd3);
        inh_ir = 1'b0;

        // Carry low -> high
        inh_cy = 1'b0;
        csr_wr(12'hB80, 32'h0);
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        check("carry_pre", mcycle, 64'h0000_0000_FFFF_FFFF);
        step();
        check("carry_post", mcycle, 64'h0000_0001_0000_0000);

        // Full wrap: high write leaves low = 0+1 = 1, then low write
        csr_wr(12'hB80, 32'hFFFF_FFFF);
        check("hi_write_lo_inc", mcycle, 64'hFFFF_FFFF_0000_0001);
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        check("wrap_pre", mcycle, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("wrap_post", mcycle, 64'd0);

        // Low write suppresses the increment
        inc = 1'b1;
        csr_wr(12'hB02, 32'h10);
        inc = 1'b0;
        check("wr_lo_wins", minstret, 64'h10);

        // High write discards the low carry
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        csr_wr(12'hB80, 32'h5);
        check("wr_hi_wins", mcycle, 64'h0000_0005_0000_0000);

        // Set mcycle = {7,3} while frozen
        inh_cy = 1'b1;
        csr_wr(12'hB80, 32'h7);
        csr_wr(12'hB00, 32'h3);
        check("set_73", mcycle, 64'h0000_0007_0000_0003);

        csr_rd(12'hC80);
        check("rd_cycleh",     {32'd0, rdata}, 64'd7);
        check("rd_cycleh_hit", {63'd0, rd_hit}, 64'd1);
        csr_rd(12'h123);
        check("rd_unmapped",     {32'd0, rdata}, 64'd0);
        check("rd_unmapped_hit", {63'd0, rd_hit}, 64'd0);
        csr_rd(12'hC00);
        check("rd_cycle", {32'd0, rdata}, 64'd3);
        step();
        check("rd_hold", {32'd0, rdata}, 64'd3);

        // Simultaneous read and write of the same CSR
        rd_en = 1'b1;
        csr_wr(12'hB00, 32'h55);
        rd_en = 1'b0;
        check("rdwr_old",  {32'd0, rdata}, 64'd3);
        check("rdwr_land", mcycle, 64'h0000_0007_0000_0055);

        csr_rd(12'hC02);
        check("rd_instret", {32'd0, rdata}, 64'h10);
        csr_rd(12'hB82);
        check("rd_minstreth", {32'd0, rdata}, 64'h0);

        // Writes to read-only aliases
        csr_wr(12'hC02, 32'hAA);
        check("alias_illegal",  {63'd0, illegal}, 64'd1);
        check("alias_minstret", minstret, 64'h10);
        step();
        check("alias_pulse_end", {63'd0, illegal}, 64'd0);
        csr_wr(12'hC80, 32'h1234);
        check("aliash_illegal", {63'd0, illegal}, 64'd1);
        check("aliash_mcycle",  mcycle, 64'h0000_0007_0000_0055);
        csr_wr(12'hB00, 32'h1);
        check("legal_no_illegal", {63'd0, illegal}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_machine_counters

`default_nettype wire
